io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Parametrised multi-port general-purpose I/O controller for the microcontroller; the successor to the fixed single-input, single-output port pair.
- Provides NUM_PORTS ports of WIDTH bits each, all reachable through one register interface on the internal data bus.
- Each port has:
  - a latched output register;
  - a synchronised input register;
  - change-detect interrupt flags with per-bit masking.
- A combined interrupt request goes to the core.

Parameters:
- NUM_PORTS, 2, number of I/O ports (1..8).
- WIDTH, 16, bits per port and bus data width.
- ADDR_W, $clog2(NUM_PORTS)+2, register address width (4 registers per port).
- DEBOUNCE_CYCLES, 4, stable-cycle count required by the optional debounce filter (2..255).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- bus_addr  in  ADDR_W  register address, encoded as {port_index, reg_sel[1:0]}.
- bus_wr_en  in  1  write strobe, one cycle.
- bus_rd_en  in  1  read strobe, one cycle.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  read data, registered.
- bus_rvalid  out  1  high for one cycle when bus_rdata is valid.
- port_in  in  NUM_PORTS*WIDTH  asynchronous pin inputs; port p occupies bits [p*WIDTH +: WIDTH].
- port_out  out  NUM_PORTS*WIDTH  output latches, same packing as port_in.
- irq  out  1  OR over all ports of (FLAG & MASK), registered.

Behaviour:
- Register map (reg_sel): 0=OUT (R/W), 1=IN (RO), 2=MASK (R/W), 3=FLAG (R, write-1-to-clear).
- Reset, asserted asynchronously:
  - port_out, MASK, FLAG, bus_rdata, bus_rvalid and irq all go to 0;
  - the synchroniser and previous-value registers also go to 0.
  - Reset asserted mid-transaction aborts the transaction; no partial write is retained.
- Write:
  - bus_wr_en at edge k updates OUT/MASK at edge k.
  - port_out reflects the new value immediately after edge k (no added latency).
  - A write to IN has no effect.
- Read:
  - bus_rd_en sampled at edge k gives bus_rdata and bus_rvalid=1 after edge k, valid for one cycle.
  - bus_rvalid returns to 0 on the next edge; bus_rdata holds its last value.
- Simultaneous rd_en and wr_en to the same register: read returns the pre-write value.
- Out-of-range port_index (>= NUM_PORTS): writes are ignored; reads return 0 with bus_rvalid=1.
- Input path:
  - Two-flop synchroniser per bit. A pin change set up before edge k appears in IN after edge k+1.
  - Change detect compares IN with the previous IN. FLAG bit is set at edge k+2 on any transition.
  - irq updates at edge k+3.
- FLAG boundary conditions:
  - Set and clear on the same bit in the same cycle: set wins.
  - FLAG bits are sticky until cleared, regardless of MASK.
- irq deasserts one cycle after the last masked flag is cleared or masked off.

Optional Feature:
- Macro: IO_PORT_DEBOUNCE_EN.
- Defined:
  - A per-port counter, $clog2(DEBOUNCE_CYCLES+1) bits, sits after the synchroniser.
  - The counter resets whenever the synchronised value differs from the candidate.
  - The candidate is copied into IN only after DEBOUNCE_CYCLES consecutive stable cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach IN or FLAG.
  - Latency grows by DEBOUNCE_CYCLES cycles.
- Undefined: no counter logic is instantiated; latency is exactly as stated above.

Decomposition:
- Shared package io_port_pkg holds:
  - the reg_sel constants REG_OUT=2'd0, REG_IN=2'd1, REG_MASK=2'd2, REG_FLAG=2'd3;
  - the default WIDTH constant.
- One sub-module: io_port_channel, generated NUM_PORTS times. It holds the synchroniser, optional debounce, OUT/MASK/FLAG registers and its per-port irq term.
- io_port_bank itself holds:
  - address decode;
  - the read mux;
  - the irq OR and its register.

Test Plan:
- Reset: hold rst=0, drive port_in=all 1s -> port_out=0, irq=0, bus_rvalid=0. Release, then read FLAG port0 -> 16'h0000.
- Output write: write 16'hA5A5 to addr {1,OUT} -> port_out[31:16]=16'hA5A5 after the same edge; port0 stays 0. Read back -> bus_rvalid pulse with 16'hA5A5.
- Input and flag:
  - Drive port0 pins 16'hF0F0 from 0 -> IN port0 reads 16'hF0F0 two edges later and FLAG=16'hF0F0.
  - With MASK=16'h00F0, irq=1 one edge after the flag sets.
  - Write FLAG 16'h00F0 -> irq=0 next cycle, FLAG=16'hF000.
- Set/clear collision: toggle port0 bit0 on the same cycle as a write-1-to-clear of bit0 -> FLAG bit0 remains 1.
- Out-of-range address: NUM_PORTS=2, write to port_index 3 -> no port_out change; read -> 0 with bus_rvalid=1.
- Debounce (macro defined, DEBOUNCE_CYCLES=4):
  - A 3-cycle pulse on port0 bit2 -> IN and FLAG unchanged.
  - A 6-cycle pulse -> IN bit2=1 and FLAG bit2=1.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the io_port_bank GPIO controller: register selects and default width.
package io_port_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   localparam logic [1:0] REG_OUT  = 2'd0;
   localparam logic [1:0] REG_IN   = 2'd1;
   localparam logic [1:0] REG_MASK = 2'd2;
   localparam logic [1:0] REG_FLAG = 2'd3;

endpackage

// File: rtl/io_port_channel.sv
// One GPIO port: input synchroniser, OUT/MASK/FLAG registers and its interrupt term.
// Define IO_PORT_DEBOUNCE_EN to add a per-port debounce filter behind the synchroniser.
module io_port_channel
   import io_port_pkg::*;
#(
   parameter int unsigned WIDTH           = DEFAULT_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins,
   input  logic             wr_out,
   input  logic             wr_mask,
   input  logic             wr_flag,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] in_q,
   output logic [WIDTH-1:0] mask_q,
   output logic [WIDTH-1:0] flag_q,
   output logic             irq_term_c
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
      $error("io_port_channel: DEBOUNCE_CYCLES must be in 2..255");
   end

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] clr_c;

`ifdef IO_PORT_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] cnt;

   // A new candidate counts as its first stable sample; IN loads after DEBOUNCE_CYCLES of them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         cand  <= '0;
         cnt   <= '0;
         in_q  <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= CNT_W'(1);
         end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               in_q <= cand;
            end
         end
      end
   end
`else
   // Two-flop synchroniser; the second stage is the IN register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         in_q  <= '0;
      end else begin
         sync1 <= pins;
         in_q  <= sync1;
      end
   end
`endif

   assign clr_c      = wr_flag ? wdata : '0;
   assign irq_term_c = |(flag_q & mask_q);

   // Change detection ORs in after the clear so a same-cycle set wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= '0;
         mask_q <= '0;
         flag_q <= '0;
         prev_q <= '0;
      end else begin
         prev_q <= in_q;
         flag_q <= (flag_q & ~clr_c) | (in_q ^ prev_q);
         if (wr_out) begin
            out_q <= wdata;
         end
         if (wr_mask) begin
            mask_q <= wdata;
         end
      end
   end

endmodule

// File: rtl/io_port_bank.sv
// Multi-port GPIO controller: address decode, registered read mux and combined irq.
// Build with IO_PORT_DEBOUNCE_EN defined to enable the per-port input debounce filter.
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned WIDTH           = DEFAULT_WIDTH,
   parameter int unsigned ADDR_W          = $clog2(NUM_PORTS) + 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          bus_addr,
   input  logic                       bus_wr_en,
   input  logic                       bus_rd_en,
   input  logic [WIDTH-1:0]           bus_wdata,
   output logic [WIDTH-1:0]           bus_rdata,
   output logic                       bus_rvalid,
   input  logic [NUM_PORTS*WIDTH-1:0] port_in,
   output logic [NUM_PORTS*WIDTH-1:0] port_out,
   output logic                       irq
);

   if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
      $error("io_port_bank: NUM_PORTS must be in 1..8");
   end

   // A single-port bank has no index bits; pad so the decode stays uniform.
   localparam int unsigned IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

   logic [IDX_W+1:0]     addr_ext;
   logic [IDX_W-1:0]     port_idx;
   logic [1:0]           reg_sel;
   logic [WIDTH-1:0]     out_v  [NUM_PORTS];
   logic [WIDTH-1:0]     in_v   [NUM_PORTS];
   logic [WIDTH-1:0]     mask_v [NUM_PORTS];
   logic [WIDTH-1:0]     flag_v [NUM_PORTS];
   logic [NUM_PORTS-1:0] irq_terms;
   logic [WIDTH-1:0]     rd_mux_c;

   assign addr_ext = (IDX_W + 2)'(bus_addr);
   assign port_idx = addr_ext[IDX_W+1:2];
   assign reg_sel  = addr_ext[1:0];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic sel_c;
      assign sel_c = (port_idx == IDX_W'(p));

      io_port_channel #(
         .WIDTH           (WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_channel (
         .clk        (clk),
         .rst        (rst),
         .pins       (port_in[p*WIDTH +: WIDTH]),
         .wr_out     (bus_wr_en && sel_c && (reg_sel == REG_OUT)),
         .wr_mask    (bus_wr_en && sel_c && (reg_sel == REG_MASK)),
         .wr_flag    (bus_wr_en && sel_c && (reg_sel == REG_FLAG)),
         .wdata      (bus_wdata),
         .out_q      (out_v[p]),
         .in_q       (in_v[p]),
         .mask_q     (mask_v[p]),
         .flag_q     (flag_v[p]),
         .irq_term_c (irq_terms[p])
      );

      assign port_out[p*WIDTH +: WIDTH] = out_v[p];
   end

   // Unmatched (out-of-range) indices fall through to zero.
   always_comb begin
      rd_mux_c = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_idx == IDX_W'(p)) begin
            case (reg_sel)
               REG_OUT:  rd_mux_c = out_v[p];
               REG_IN:   rd_mux_c = in_v[p];
               REG_MASK: rd_mux_c = mask_v[p];
               default:  rd_mux_c = flag_v[p];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
         irq        <= 1'b0;
      end else begin
         bus_rvalid <= bus_rd_en;
         if (bus_rd_en) begin
            bus_rdata <= rd_mux_c;
         end
         irq <= |irq_terms;
      end
   end

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: reads push expected data, a negedge monitor pops on bus_rvalid.
module tb_io_port_bank;

`ifdef IO_PORT_DEBOUNCE_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 0;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  bus_addr;
   logic        bus_wr_en;
   logic        bus_rd_en;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_rvalid;
   logic [31:0] port_in;
   logic [31:0] port_out;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q  [$];
   string       name_q [$];

   io_port_bank #(
      .NUM_PORTS       (2),
      .WIDTH           (16),
      .ADDR_W          (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_addr   (bus_addr),
      .bus_wr_en  (bus_wr_en),
      .bus_rd_en  (bus_rd_en),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .port_in    (port_in),
      .port_out   (port_out),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every read response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rvalid: got rdata %h, expected no response", bus_rdata);
         end else begin
            check(name_q.pop_front(), 32'(bus_rdata), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      bus_addr  = a;
      bus_wdata = d;
      bus_wr_en = 1'b1;
      @(posedge clk);
      #1 bus_wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [15:0] exp, input string name);
      @(negedge clk);
      bus_addr  = a;
      bus_rd_en = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1 bus_rd_en = 1'b0;
   endtask

   task automatic bus_rw(input logic [3:0] a, input logic [15:0] d, input logic [15:0] exp,
                         input string name);
      @(negedge clk);
      bus_addr  = a;
      bus_wdata = d;
      bus_wr_en = 1'b1;
      bus_rd_en = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      bus_wr_en = 1'b0;
      bus_rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      bus_addr  = '0;
      bus_wr_en = 1'b0;
      bus_rd_en = 1'b0;
      bus_wdata = '0;
      port_in   = '1;

      // Reset state with pins driven high
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_port_out", port_out, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_rvalid", 32'(bus_rvalid), 32'h0);
      port_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      bus_read(4'd3, 16'h0000, "flag0_after_reset");

      // Output write lands on the same edge
      bus_write(4'd4, 16'hA5A5);
      check("port1_out_write", port_out, 32'hA5A5_0000);
      bus_read(4'd4, 16'hA5A5, "port1_out_read");

      // Input change -> FLAG -> irq timing
      bus_write(4'd2, 16'h00F0);
      @(negedge clk);
      port_in[15:0] = 16'hF0F0;
      repeat (3 + LAT) @(posedge clk);
      #1 check("irq_before_flag", 32'(irq), 32'h0);
      @(posedge clk);
      #1 check("irq_after_flag", 32'(irq), 32'h1);
      bus_read(4'd1, 16'hF0F0, "in0_read");
      bus_read(4'd3, 16'hF0F0, "flag0_read");

      // Write-1-to-clear drops irq one cycle later
      bus_write(4'd3, 16'h00F0);
      #0 check("irq_hold_on_clear_edge", 32'(irq), 32'h1);
      @(posedge clk);
      #1 check("irq_after_clear", 32'(irq), 32'h0);
      bus_read(4'd3, 16'hF000, "flag0_after_clear");

      // Set/clear collision on bit0: set wins
      @(negedge clk);
      port_in[0] = 1'b1;
      repeat (6 + LAT) @(posedge clk);
      @(negedge clk);
      port_in[0] = 1'b0;
      repeat (2 + LAT) @(posedge clk);
      bus_write(4'd3, 16'h0001);
      bus_read(4'd3, 16'hF001, "flag_collision");
      bus_write(4'd3, 16'h0001);
      bus_read(4'd3, 16'hF000, "flag_clear_bit0");

      // Out-of-range port index
      bus_write(4'd12, 16'hFFFF);
      bus_write(4'd14, 16'hFFFF);
      check("oor_write_ignored", port_out, 32'hA5A5_0000);
      bus_read(4'd12, 16'h0000, "oor_read_out");
      bus_read(4'd15, 16'h0000, "oor_read_flag");

      // Simultaneous read and write returns the pre-write value
      bus_rw(4'd0, 16'h1234, 16'h0000, "rw_same_reg");
      check("port0_out_write", port_out, 32'hA5A5_1234);
      bus_read(4'd0, 16'h1234, "port0_out_read");

      // irq follows MASK changes with one cycle of latency
      bus_write(4'd2, 16'hF000);
      @(posedge clk);
      #1 check("irq_mask_on", 32'(irq), 32'h1);
      bus_write(4'd2, 16'h0000);
      @(posedge clk);
      #1 check("irq_mask_off", 32'(irq), 32'h0);
      bus_read(4'd2, 16'h0000, "mask0_read");

`ifdef IO_PORT_DEBOUNCE_EN
      // 3-cycle glitch is filtered out
      @(negedge clk);
      port_in[2] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      port_in[2] = 1'b0;
      repeat (12) @(posedge clk);
      bus_read(4'd1, 16'hF0F0, "glitch_in");
      bus_read(4'd3, 16'hF000, "glitch_flag");

      // Longer pulse passes the filter
      @(negedge clk);
      port_in[2] = 1'b1;
      repeat (6) @(posedge clk);
      bus_read(4'd1, 16'hF0F4, "pulse_in");
      @(negedge clk);
      port_in[2] = 1'b0;
      repeat (12) @(posedge clk);
      bus_read(4'd3, 16'hF004, "pulse_flag");
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
